// File: rtl/channel_pole_bank_if.sv
// Configuration, streaming-input and output signals of the channel pole bank.
// The bench drives through the master modport; channel_pole_bank uses the slave modport.
interface channel_pole_bank_if #(
  parameter int NUM_SEC = 6,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 18,
  parameter int STATE_W = 32
);
  localparam int SEC_W = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

  logic                       cfg_we;
  logic [SEC_W-1:0]           cfg_sec;
  logic [2:0]                 cfg_sel;
  logic signed [COEF_W-1:0]   cfg_data;
  logic                       cfg_ready;
  logic                       clr_state;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   in_x;
  logic                       out_valid;
  logic signed [STATE_W-1:0]  out_y;

  modport master (
    output cfg_we, cfg_sec, cfg_sel, cfg_data, clr_state, in_valid, in_x,
    input  cfg_ready, in_ready, out_valid, out_y
  );

  modport slave (
    input  cfg_we, cfg_sec, cfg_sel, cfg_data, clr_state, in_valid, in_x,
    output cfg_ready, in_ready, out_valid, out_y
  );
endinterface

// File: rtl/channel_pole_bank.sv
// Bank of NUM_SEC complex one-pole IIR sections plus a DC path, sharing one complex MAC.
// Define CHAN_SAT_EN to saturate every reduction to STATE_W; otherwise results wrap.
module channel_pole_bank #(
  parameter int NUM_SEC = 6,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 18,
  parameter int FRAC_W  = 16,
  parameter int STATE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  channel_pole_bank_if.slave bus
);
  localparam int SEC_W  = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam int MAX_W  = (STATE_W > DATA_W) ? STATE_W : DATA_W;
  // Headroom covers the three-product sum and accumulation of up to 16 sections.
  localparam int FULL_W = COEF_W + MAX_W + 6;
  localparam logic [SEC_W-1:0] LAST_IDX = SEC_W'(NUM_SEC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

`ifdef CHAN_SAT_EN
  localparam logic signed [FULL_W-1:0] SAT_MAX = {{(FULL_W-STATE_W+1){1'b0}}, {(STATE_W-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_MIN = {{(FULL_W-STATE_W+1){1'b1}}, {(STATE_W-1){1'b0}}};
`endif

  function automatic logic signed [STATE_W-1:0] reduce(input logic signed [FULL_W-1:0] v);
`ifdef CHAN_SAT_EN
    if (v > SAT_MAX)      return SAT_MAX[STATE_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[STATE_W-1:0];
    else                  return v[STATE_W-1:0];
`else
    return v[STATE_W-1:0];
`endif
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [SEC_W-1:0]           idx_q, idx_d;
  logic signed [DATA_W-1:0]   x_q, x_d;
  logic signed [FULL_W-1:0]   sum_q, sum_d;
  logic signed [STATE_W-1:0]  out_y_q, out_y_d;
  logic signed [COEF_W-1:0]   dc_q, dc_d;
  logic signed [COEF_W-1:0]   gr_q [NUM_SEC], gr_d [NUM_SEC];
  logic signed [COEF_W-1:0]   gi_q [NUM_SEC], gi_d [NUM_SEC];
  logic signed [COEF_W-1:0]   er_q [NUM_SEC], er_d [NUM_SEC];
  logic signed [COEF_W-1:0]   ei_q [NUM_SEC], ei_d [NUM_SEC];
  logic signed [STATE_W-1:0]  ar_q [NUM_SEC], ar_d [NUM_SEC];
  logic signed [STATE_W-1:0]  ai_q [NUM_SEC], ai_d [NUM_SEC];

  logic signed [FULL_W-1:0]   ar_e, ai_e, x_e, re_acc, im_acc, dc_term;
  logic signed [STATE_W-1:0]  ar_new, ai_new, out_y_calc;
  logic                       accept, cfg_hit;

  assign bus.in_ready  = (state_q != S_CALC);
  assign bus.cfg_ready = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT) && !bus.clr_state;
  assign bus.out_y     = bus.out_valid ? out_y_calc : out_y_q;

  assign accept  = bus.in_valid && bus.in_ready && !bus.clr_state;
  assign cfg_hit = bus.cfg_we && bus.cfg_ready &&
                   ((int'(bus.cfg_sel) == 4) || (int'(bus.cfg_sec) < NUM_SEC));

  // Shared complex MAC: operates on the old state of section idx_q only.
  always_comb begin
    ar_e       = FULL_W'(ar_q[idx_q]);
    ai_e       = FULL_W'(ai_q[idx_q]);
    x_e        = FULL_W'(x_q);
    re_acc     = FULL_W'(er_q[idx_q]) * ar_e - FULL_W'(ei_q[idx_q]) * ai_e
               + FULL_W'(gr_q[idx_q]) * x_e;
    im_acc     = FULL_W'(ei_q[idx_q]) * ar_e + FULL_W'(er_q[idx_q]) * ai_e
               + FULL_W'(gi_q[idx_q]) * x_e;
    ar_new     = reduce(re_acc >>> FRAC_W);
    ai_new     = reduce(im_acc >>> FRAC_W);
    dc_term    = (FULL_W'(dc_q) * x_e) >>> FRAC_W;
    out_y_calc = reduce(sum_q + dc_term);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    sum_d   = sum_q;
    out_y_d = bus.out_valid ? out_y_calc : out_y_q;
    dc_d    = dc_q;
    gr_d    = gr_q;
    gi_d    = gi_q;
    er_d    = er_q;
    ei_d    = ei_q;
    ar_d    = ar_q;
    ai_d    = ai_q;

    if (cfg_hit) begin
      case (bus.cfg_sel)
        3'd0:    gr_d[bus.cfg_sec] = bus.cfg_data;
        3'd1:    gi_d[bus.cfg_sec] = bus.cfg_data;
        3'd2:    er_d[bus.cfg_sec] = bus.cfg_data;
        3'd3:    ei_d[bus.cfg_sec] = bus.cfg_data;
        3'd4:    dc_d = bus.cfg_data;
        default: ;
      endcase
    end

    case (state_q)
      S_CALC: begin
        ar_d[idx_q] = ar_new;
        ai_d[idx_q] = ai_new;
        sum_d       = sum_q + FULL_W'(ar_new);
        if (idx_q == LAST_IDX) state_d = S_OUT;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_OUT:   state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      state_d = S_CALC;
      idx_d   = '0;
      x_d     = bus.in_x;
      sum_d   = '0;
    end

    // Clear wins over everything in flight; coefficients are kept.
    if (bus.clr_state) begin
      for (int i = 0; i < NUM_SEC; i++) begin
        ar_d[i] = '0;
        ai_d[i] = '0;
      end
      state_d = S_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      sum_q   <= '0;
      out_y_q <= '0;
      dc_q    <= '0;
      for (int i = 0; i < NUM_SEC; i++) begin
        gr_q[i] <= '0;
        gi_q[i] <= '0;
        er_q[i] <= '0;
        ei_q[i] <= '0;
        ar_q[i] <= '0;
        ai_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      sum_q   <= sum_d;
      out_y_q <= out_y_d;
      dc_q    <= dc_d;
      gr_q    <= gr_d;
      gi_q    <= gi_d;
      er_q    <= er_d;
      ei_q    <= ei_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
    end
  end
endmodule
